// File: rtl/prom_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : prom_fetch
//  Description : Instruction fetch stage. Owns the program counter, drives the
//                program ROM address, captures {pc, word} into a small FIFO
//                and hands instructions to decode over valid/ready. Supports
//                jump redirect (flushes the FIFO) and halt (PC held, drains).
//  Revision    : 1.0 - initial release
// ============================================================================
module prom_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2     // power of two, >= 2
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [ADDR_W-1:0] prom_addr,
    input  logic [DATA_W-1:0] prom_data,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_busy
);

    localparam int               C_PTR_W   = $clog2(DEPTH);
    localparam int               C_CNT_W   = C_PTR_W + 1;
    localparam int               C_ENTRY_W = ADDR_W + DATA_W;
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_ENTRY_W-1:0] mem_q [DEPTH];

    logic w_valid;
    logic w_pop;
    logic w_push;

    // Head is hidden during a jump cycle so the stale entry cannot be popped.
    assign w_valid = (count_q != '0) & ~jump_valid;
    assign w_pop   = w_valid & instr_ready;
    // A full FIFO still accepts a fetch when the head leaves in the same cycle.
    assign w_push  = ~RST & ~jump_valid & ~halt & ((count_q < C_DEPTH) | w_pop);

    // Next-state for PC, occupancy and pointers; jump flushes and redirects.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (jump_valid) begin
            pc_d     = jump_addr;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) begin
                pc_d     = pc_q + ADDR_W'(1);      // silent wrap at top of space
                wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + C_CNT_W'(1);
                2'b01:   count_d = count_q - C_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= {pc_q, prom_data};
        end
    end

    assign prom_addr              = pc_q;
    assign instr_valid            = w_valid;
    assign {instr_pc, instr_data} = mem_q[rd_ptr_q];
    assign fetch_busy             = (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_prom_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prom_fetch
//  Description : Directed self-checking bench for prom_fetch (stream,
//                backpressure, jump flush, halt, PC wrap, mid-run reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prom_fetch;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] prom_addr;
    logic [31:0] prom_data;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_addr  = '0;
    logic        halt       = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic        fetch_busy;

    int n_tests = 0;
    int n_fail  = 0;

    prom_fetch #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .RESET_PC (16'h0000),
        .DEPTH    (2)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .prom_addr   (prom_addr),
        .prom_data   (prom_data),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .fetch_busy  (fetch_busy)
    );

    always #5 CLK = ~CLK;

    // Bench ROM: three fixed words, everything else is {~addr, addr}.
    function automatic logic [31:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: rom = 32'h000A0007;
            16'h0001: rom = 32'h00032007;
            16'h0002: rom = 32'h00004007;
            default:  rom = {~a, a};
        endcase
    endfunction

    assign prom_data = rom(prom_addr);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic reset_dut();
        @(negedge CLK);
        RST        = 1'b1;
        jump_valid = 1'b0;
        halt       = 1'b0;
        @(negedge CLK);
        RST        = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [15:0] pc);
        check_eq({tag, "_valid"}, 64'(instr_valid), 64'(1'b1));
        check_eq({tag, "_pc"},    64'(instr_pc),    64'(pc));
        check_eq({tag, "_data"},  64'(instr_data),  64'(rom(pc)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset then stream ----------------
        instr_ready = 1'b1;
        reset_dut();
        check_eq("rst_valid", 64'(instr_valid), 64'(1'b0));
        check_eq("rst_busy",  64'(fetch_busy),  64'(1'b0));
        check_eq("rst_addr",  64'(prom_addr),   64'(16'h0000));
        check_eq("rst_pc",    64'(instr_pc),    64'(16'h0000));
        check_eq("rst_data",  64'(instr_data),  64'(32'h0));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_head("stream", 16'(i));
        end

        // ---------------- backpressure ----------------
        instr_ready = 1'b0;
        reset_dut();
        repeat (5) @(negedge CLK);
        check_eq("bp_addr_stall", 64'(prom_addr),  64'(16'h0002));
        check_eq("bp_busy",       64'(fetch_busy), 64'(1'b1));
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge CLK);
            check_head("bp_drain", 16'(i));
        end
        // FIFO now holds pcs 3,4 and prom_addr is 5

        // ---------------- jump flush ----------------
        jump_valid = 1'b1;
        jump_addr  = 16'h0005;
        #1;
        check_eq("jmp_mask", 64'(instr_valid), 64'(1'b0));
        @(negedge CLK);
        jump_valid = 1'b0;
        #1;
        check_eq("jmp_next_valid", 64'(instr_valid), 64'(1'b0));
        check_eq("jmp_flush_busy", 64'(fetch_busy),  64'(1'b0));
        check_eq("jmp_addr",       64'(prom_addr),   64'(16'h0005));
        @(negedge CLK);
        check_head("jmp_first", 16'h0005);
        @(negedge CLK);
        check_head("jmp_second", 16'h0006);
        check_eq("halt_pre_addr", 64'(prom_addr), 64'(16'h0007));

        // ---------------- halt ----------------
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_eq("halt_addr",  64'(prom_addr),   64'(16'h0007));
            check_eq("halt_valid", 64'(instr_valid), 64'(1'b0));
        end
        halt = 1'b0;
        @(negedge CLK);
        check_head("halt_resume", 16'h0007);
        @(negedge CLK);
        check_head("halt_resume2", 16'h0008);

        // ---------------- PC wrap ----------------
        jump_valid = 1'b1;
        jump_addr  = 16'hFFFF;
        @(negedge CLK);
        jump_valid = 1'b0;
        @(negedge CLK);
        check_head("wrap_ffff", 16'hFFFF);
        @(negedge CLK);
        check_head("wrap_0000", 16'h0000);
        @(negedge CLK);
        check_head("wrap_0001", 16'h0001);

        // ---------------- mid-operation reset ----------------
        instr_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("mrst_full_busy", 64'(fetch_busy), 64'(1'b1));
        RST         = 1'b1;
        jump_valid  = 1'b1;
        jump_addr   = 16'h1234;
        instr_ready = 1'b1;
        @(negedge CLK);
        RST        = 1'b0;
        jump_valid = 1'b0;
        #1;
        check_eq("mrst_valid", 64'(instr_valid), 64'(1'b0));
        check_eq("mrst_busy",  64'(fetch_busy),  64'(1'b0));
        check_eq("mrst_addr",  64'(prom_addr),   64'(16'h0000));
        @(negedge CLK);
        check_head("mrst_first", 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
